// File: rtl/image_sensor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : image_sensor_pkg
//  Description : Shared types and helpers for the image sensor model:
//                FSM state encoding, frame period and blank-counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package image_sensor_pkg;

    // Sensor readout phases, explicitly 3 bits wide
    typedef enum logic [2:0] {
        S_VBLANK   = 3'd0,
        S_FV_LEAD  = 3'd1,
        S_LINE     = 3'd2,
        S_HBLANK   = 3'd3,
        S_LV_TRAIL = 3'd4
    } state_t;

    // Extclk cycles from one frame start to the next
    function automatic int frame_period(input int columns, input int rows,
                                        input int v_blank, input int fv_lead,
                                        input int h_blank, input int lv_trail);
        return v_blank + fv_lead + rows * columns + (rows - 1) * h_blank + lv_trail;
    endfunction

    // Longest blanking interval, used to size the shared blank counter
    function automatic int blank_max(input int a, input int b,
                                     input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage : image_sensor_pkg
`default_nettype wire

// File: rtl/image_sensor_model.sv
`default_nettype none
// ============================================================================
//  Module      : image_sensor_model
//  Description : Synthesizable model of a 12-bit parallel CMOS image sensor.
//                Emits frame_valid/line_valid framing and a ramp image whose
//                pixel value is row*COLUMNS+col (mod 2^DATA_WIDTH).
//  Revision    : 1.0 - initial release
// ============================================================================
module image_sensor_model
    import image_sensor_pkg::*;
#(
    parameter int COLUMNS    = 14,
    parameter int ROWS       = 12,
    parameter int V_BLANK    = 16,
    parameter int FV_LEAD    = 4,
    parameter int H_BLANK    = 8,
    parameter int LV_TRAIL   = 4,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  extclk,
    input  logic                  reset,
    output logic                  pixclk,
    output logic                  frame_valid,
    output logic                  line_valid,
    output logic [DATA_WIDTH-1:0] dout
);

    if (COLUMNS < 2 || ROWS < 1 || V_BLANK < 1 || FV_LEAD < 1 ||
        H_BLANK < 1 || LV_TRAIL < 1 || DATA_WIDTH < 1) begin : g_param_check
        $fatal(1, "image_sensor_model: illegal parameter value");
    end

    localparam int c_CNT_W = $clog2(blank_max(V_BLANK, FV_LEAD, H_BLANK, LV_TRAIL) + 1);
    localparam int c_COL_W = $clog2(COLUMNS + 1);
    localparam int c_ROW_W = $clog2(ROWS + 1);

    localparam logic [c_CNT_W-1:0] c_VB_LAST = c_CNT_W'(V_BLANK - 1);
    localparam logic [c_CNT_W-1:0] c_FL_LAST = c_CNT_W'(FV_LEAD - 1);
    localparam logic [c_CNT_W-1:0] c_HB_LAST = c_CNT_W'(H_BLANK - 1);
    localparam logic [c_CNT_W-1:0] c_LT_LAST = c_CNT_W'(LV_TRAIL - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(COLUMNS - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(ROWS - 1);

    state_t                  r_state, w_next_state;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_next;
    logic [c_COL_W-1:0]      r_col, w_col_next;
    logic [c_ROW_W-1:0]      r_row, w_row_next;
    logic [DATA_WIDTH-1:0]   r_pix, w_pix_next;

    logic                    r_frame_valid, r_line_valid;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    w_fv, w_lv;
    logic [DATA_WIDTH-1:0]   w_dout;

    // Forwarded clock: receiver samples mid-way between output transitions
    assign pixclk      = ~extclk;
    assign frame_valid = r_frame_valid;
    assign line_valid  = r_line_valid;
    assign dout        = r_dout;

    // State register plus blank, column, row and pixel-value counters
    always_ff @(posedge extclk) begin
        if (reset) begin
            r_state <= S_VBLANK;
            r_cnt   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_pix   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_col   <= w_col_next;
            r_row   <= w_row_next;
            r_pix   <= w_pix_next;
        end
    end

    // Next-state logic and output decode of the current phase
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_col_next   = r_col;
        w_row_next   = r_row;
        w_pix_next   = r_pix;
        w_fv         = 1'b1;
        w_lv         = 1'b0;
        w_dout       = '0;
        case (r_state)
            S_VBLANK: begin
                w_fv       = 1'b0;
                // Ramp restarts at zero for every frame
                w_pix_next = '0;
                w_row_next = '0;
                w_col_next = '0;
                if (r_cnt == c_VB_LAST) begin
                    w_next_state = S_FV_LEAD;
                    w_cnt_next   = '0;
                end
            end
            S_FV_LEAD: begin
                if (r_cnt == c_FL_LAST) begin
                    w_next_state = S_LINE;
                    w_cnt_next   = '0;
                end
            end
            S_LINE: begin
                w_lv       = 1'b1;
                w_dout     = r_pix;
                w_pix_next = r_pix + 1'b1;
                w_cnt_next = '0;
                if (r_col == c_COL_LAST) begin
                    w_col_next   = '0;
                    w_next_state = (r_row == c_ROW_LAST) ? S_LV_TRAIL : S_HBLANK;
                end else begin
                    w_col_next = r_col + 1'b1;
                end
            end
            S_HBLANK: begin
                if (r_cnt == c_HB_LAST) begin
                    w_next_state = S_LINE;
                    w_cnt_next   = '0;
                    w_row_next   = r_row + 1'b1;
                end
            end
            S_LV_TRAIL: begin
                if (r_cnt == c_LT_LAST) begin
                    w_next_state = S_VBLANK;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_next_state = S_VBLANK;
                w_cnt_next   = '0;
                w_fv         = 1'b0;
            end
        endcase
    end

    // Registered outputs lag the phase by one edge; reset blanks them at once
    always_ff @(posedge extclk) begin
        if (reset) begin
            r_frame_valid <= 1'b0;
            r_line_valid  <= 1'b0;
            r_dout        <= '0;
        end else begin
            r_frame_valid <= w_fv;
            r_line_valid  <= w_lv;
            r_dout        <= w_dout;
        end
    end

endmodule : image_sensor_model
`default_nettype wire

// File: tb/tb_image_sensor_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_sensor_model
//  Description : Self-checking bench for image_sensor_model (default and
//                100x50 wrap-around configurations) using expected-output
//                queues built from an independent frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_sensor_model;
    import image_sensor_pkg::*;

    localparam int c_DW = 12;

    logic            extclk = 1'b0;
    logic            reset  = 1'b1;
    logic            pixclk_s, fv_s, lv_s;
    logic [c_DW-1:0] dout_s;
    logic            pixclk_b, fv_b, lv_b;
    logic [c_DW-1:0] dout_b;

    int n_assert = 0;
    int n_fail   = 0;

    logic [c_DW+1:0] q_s[$];
    logic [c_DW+1:0] q_b[$];

    // 10 ns extclk
    always #5 extclk = ~extclk;

    image_sensor_model u_dut_s (
        .extclk      (extclk),
        .reset       (reset),
        .pixclk      (pixclk_s),
        .frame_valid (fv_s),
        .line_valid  (lv_s),
        .dout        (dout_s)
    );

    image_sensor_model #(.COLUMNS(100), .ROWS(50)) u_dut_b (
        .extclk      (extclk),
        .reset       (reset),
        .pixclk      (pixclk_b),
        .frame_valid (fv_b),
        .line_valid  (lv_b),
        .dout        (dout_b)
    );

    // Builds the expected per-edge {frame_valid, line_valid, dout} for one frame
    task automatic push_frame(input bit big, input int cols, input int rows);
        logic [c_DW+1:0] e;
        logic [c_DW-1:0] pix;
        pix = '0;
        for (int i = 0; i < 16; i++) begin
            e = '0;
            if (big) q_b.push_back(e); else q_s.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            e = {1'b1, 1'b0, {c_DW{1'b0}}};
            if (big) q_b.push_back(e); else q_s.push_back(e);
        end
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                e = {1'b1, 1'b1, pix};
                if (big) q_b.push_back(e); else q_s.push_back(e);
                pix = pix + 1'b1;
            end
            if (r < rows - 1) begin
                for (int i = 0; i < 8; i++) begin
                    e = {1'b1, 1'b0, {c_DW{1'b0}}};
                    if (big) q_b.push_back(e); else q_s.push_back(e);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            e = {1'b1, 1'b0, {c_DW{1'b0}}};
            if (big) q_b.push_back(e); else q_s.push_back(e);
        end
    endtask

    task automatic chk(input string tag, input logic [c_DW+1:0] obs,
                       input logic [c_DW+1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One extclk edge: scoreboard compare plus protocol rules on both DUTs
    task automatic step();
        logic [c_DW+1:0] e;
        @(posedge extclk);
        #1;
        chk("pixclk_inv", {13'd0, pixclk_s}, {13'd0, ~extclk});
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            chk("small_out", {fv_s, lv_s, dout_s}, e);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("big_out", {fv_b, lv_b, dout_b}, e);
        end
        chk("small_lv_in_fv", {13'd0, lv_s & ~fv_s}, '0);
        chk("small_dout_idle", (lv_s ? '0 : {2'b00, dout_s}), '0);
        chk("big_lv_in_fv", {13'd0, lv_b & ~fv_b}, '0);
        chk("big_dout_idle", (lv_b ? '0 : {2'b00, dout_b}), '0);
    endtask

    // Directed sequence
    initial begin
        int per_s, per_b;
        per_s = frame_period(14, 12, 16, 4, 8, 4);
        per_b = frame_period(100, 50, 16, 4, 8, 4);

        // Reset held: all outputs low, pixclk is the inverse of extclk
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rst_small", {fv_s, lv_s, dout_s}, '0);
            chk("rst_big", {fv_b, lv_b, dout_b}, '0);
            @(negedge extclk);
            #1;
            chk("pixclk_high", {13'd0, pixclk_s}, 14'd1);
        end

        // Release between edges; next edge is edge 0
        reset = 1'b0;
        push_frame(1'b0, 14, 12);
        push_frame(1'b0, 14, 12);
        for (int i = 0; i < 2 * per_s; i++) step();

        // Third frame up to row 5, column 7, then a one-cycle reset
        push_frame(1'b0, 14, 12);
        for (int i = 0; i < 20 + 5 * 22 + 8; i++) step();
        chk("pre_abort_pixel", {fv_s, lv_s, dout_s}, {2'b11, 12'd77});
        q_s.delete();
        reset = 1'b1;
        step();
        chk("abort_small", {fv_s, lv_s, dout_s}, '0);
        chk("abort_big", {fv_b, lv_b, dout_b}, '0);
        reset = 1'b0;

        // Restart after abort: full vertical blank, then pixel 0; two frames
        push_frame(1'b0, 14, 12);
        push_frame(1'b0, 14, 12);
        for (int i = 0; i < 2 * per_s; i++) step();

        // Large configuration: 5000-pixel ramp wraps 4095 -> 0
        reset = 1'b1;
        step();
        q_s.delete();
        reset = 1'b0;
        push_frame(1'b1, 100, 50);
        for (int i = 0; i < per_b; i++) step();
        chk("big_queue_drained", 14'(q_b.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_image_sensor_model
`default_nettype wire
